// File: rtl/muldiv_sequencer.sv
// Multiply / restoring-divide sequencer producing the unnormalised mantissa and raw exponent for the FP normaliser.
// Optional build macro: EARLY_TERM_EN stops the divide once the partial remainder reaches zero.
module muldiv_sequencer #(
    parameter int mant_width = 23,
    parameter int exp_width  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic                         op_div,
    input  logic [mant_width:0]          mant_a,
    input  logic [mant_width:0]          mant_b,
    input  logic [exp_width-1:0]         exp_a,
    input  logic [exp_width-1:0]         exp_b,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [2*mant_width+1:0]      unnorm_mant,
    output logic signed [exp_width+1:0]  unnorm_exp,
    output logic                         exc,
    output logic                         busy
);
    localparam int N  = 2*mant_width + 1;
    localparam int CW = $clog2(N + 1);
    localparam int XW = exp_width + 2;
    localparam int RW = mant_width + 2;
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (exp_width - 1)) - 1);

    typedef enum logic [2:0] {IDLE, CHK, MUL, DIV, DONE} state_t;

    state_t              state;
    logic [mant_width:0] a_q, b_q;
    logic [exp_width-1:0] ea_q, eb_q;
    logic                div_q, adj_q;
    logic [RW-1:0]       rem_q;
    logic [N-1:0]        q_q;
    logic [CW-1:0]       cnt_q;

    logic signed [XW-1:0] mul_exp, div_exp;
    logic [2*mant_width+1:0] prod;
    logic [RW-1:0]       rem_diff, rem_next;
    logic                rem_ge, div_last;
    logic [N-1:0]        q_fin;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        mul_exp  = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS;
        div_exp  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BIAS
                   - $signed({{(XW-1){1'b0}}, adj_q});
        prod     = {{(mant_width+1){1'b0}}, a_q} * {{(mant_width+1){1'b0}}, b_q};
        rem_ge   = rem_q >= {1'b0, b_q};
        rem_diff = rem_ge ? rem_q - {1'b0, b_q} : rem_q;
        rem_next = {rem_diff[RW-2:0], 1'b0};
`ifdef EARLY_TERM_EN
        div_last = (cnt_q == CW'(N)) || (rem_q == '0);
`else
        div_last = (cnt_q == CW'(N));
`endif
        // Left-align the quotient when fewer than N bits were produced.
        q_fin    = q_q << (CW'(N) - cnt_q);
    end

    // NOTE: datapath registers are reset too, so outputs read as zero after reset rather than X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_ready    <= 1'b1;
            res_valid   <= 1'b0;
            unnorm_mant <= '0;
            unnorm_exp  <= '0;
            exc         <= 1'b0;
            busy        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            ea_q        <= '0;
            eb_q        <= '0;
            div_q       <= 1'b0;
            adj_q       <= 1'b0;
            rem_q       <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            case (state)
                IDLE: if (op_valid) begin
                    a_q      <= mant_a;
                    b_q      <= mant_b;
                    ea_q     <= exp_a;
                    eb_q     <= exp_b;
                    div_q    <= op_div;
                    adj_q    <= 1'b0;
                    op_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= CHK;
                end
                CHK: if (!a_q[mant_width] || !b_q[mant_width]) begin
                    exc         <= 1'b1;
                    unnorm_mant <= '0;
                    unnorm_exp  <= div_q ? div_exp : mul_exp;
                    res_valid   <= 1'b1;
                    state       <= DONE;
                end else if (div_q) begin
                    // Pre-shift a smaller dividend so the quotient lands in [1,2).
                    if (a_q < b_q) begin
                        rem_q <= {a_q, 1'b0};
                        adj_q <= 1'b1;
                    end else begin
                        rem_q <= {1'b0, a_q};
                    end
                    q_q   <= '0;
                    cnt_q <= '0;
                    state <= DIV;
                end else begin
                    state <= MUL;
                end
                MUL: begin
                    exc         <= 1'b0;
                    unnorm_mant <= prod;
                    unnorm_exp  <= mul_exp;
                    res_valid   <= 1'b1;
                    state       <= DONE;
                end
                DIV: if (div_last) begin
                    exc         <= 1'b0;
                    unnorm_mant <= {1'b0, q_fin[N-1:1], q_fin[0] | (rem_q != '0)};
                    unnorm_exp  <= div_exp;
                    res_valid   <= 1'b1;
                    state       <= DONE;
                end else begin
                    rem_q <= rem_next;
                    q_q   <= {q_q[N-2:0], rem_ge};
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    op_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer at mant_width=3, exp_width=4 (BIAS=7, N=7).
module tb_muldiv_sequencer;
    localparam int MW = 3;
    localparam int EW = 4;
`ifdef EARLY_TERM_EN
    localparam int DIV_LAT = -1;
`else
    localparam int DIV_LAT = 10;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic op_valid = 1'b0, op_ready, op_div = 1'b0;
    logic [MW:0] mant_a = '0, mant_b = '0;
    logic [EW-1:0] exp_a = '0, exp_b = '0;
    logic res_valid, res_ready = 1'b1;
    logic [2*MW+1:0] unnorm_mant;
    logic signed [EW+1:0] unnorm_exp;
    logic exc, busy;

    muldiv_sequencer #(.mant_width(MW), .exp_width(EW)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_div(op_div), .mant_a(mant_a), .mant_b(mant_b), .exp_a(exp_a),
        .exp_b(exp_b), .res_valid(res_valid), .res_ready(res_ready),
        .unnorm_mant(unnorm_mant), .unnorm_exp(unnorm_exp), .exc(exc), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]        mant;
        logic signed [5:0] ex;
        logic              exc;
        int                lat;
        int                acc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares each newly presented result against the oldest expectation.
    logic rv_q = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && res_valid && !rv_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got mant %0h with no request pending", unnorm_mant);
            end else begin
                mon_e = sb.pop_front();
                check("unnorm_mant", {24'd0, unnorm_mant}, {24'd0, mon_e.mant});
                check("unnorm_exp", {26'd0, unnorm_exp}, {26'd0, mon_e.ex});
                check("exc", {31'd0, exc}, {31'd0, mon_e.exc});
                if (mon_e.lat >= 0)
                    check("latency", cyc - mon_e.acc, mon_e.lat);
            end
        end
        rv_q = rst_n && res_valid;
    end

    task automatic issue(input logic div, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] ea, input logic [3:0] eb,
                         input logic [7:0] em, input logic signed [5:0] ee,
                         input logic ex, input int lat);
        int n;
        exp_t e;
        @(negedge clk);
        op_valid = 1'b1; op_div = div; mant_a = a; mant_b = b; exp_a = ea; exp_b = eb;
        n = 0;
        while (!op_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: op_ready stayed %0b, expected 1", op_ready);
        end else begin
            e.mant = em; e.ex = ee; e.exc = ex; e.lat = lat; e.acc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || res_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy || res_valid) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b res_valid=%0b, expected 0 0", busy, res_valid);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_op_ready"}, {31'd0, op_ready}, 32'd1);
        check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_mant"}, {24'd0, unnorm_mant}, 32'd0);
        check({tag, "_exp"}, {26'd0, unnorm_exp}, 32'd0);
        check({tag, "_exc"}, {31'd0, exc}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // mul 1.5*1.5, div 1.5/1.0, div 1.0/1.5 (pre-shift, sticky), exc multiply
        issue(1'b0, 4'b1100, 4'b1100, 4'd8, 4'd8, 8'b10010000, 6'sd9, 1'b0, 3);  wait_idle();
        issue(1'b1, 4'b1100, 4'b1000, 4'd7, 4'd7, 8'b01100000, 6'sd7, 1'b0, DIV_LAT); wait_idle();
        issue(1'b1, 4'b1000, 4'b1100, 4'd7, 4'd7, 8'b01010101, 6'sd6, 1'b0, DIV_LAT); wait_idle();
        issue(1'b0, 4'b1100, 4'b0100, 4'd5, 4'd6, 8'b00000000, 6'sd4, 1'b1, 2);  wait_idle();
        // negative raw exponent; equal operands; 9/15 with sticky and pre-shift
        issue(1'b0, 4'b1000, 4'b1110, 4'd1, 4'd2, 8'b01110000, -6'sd4, 1'b0, 3); wait_idle();
        issue(1'b1, 4'b1000, 4'b1000, 4'd9, 4'd3, 8'b01000000, 6'sd13, 1'b0, DIV_LAT); wait_idle();
        issue(1'b1, 4'b1001, 4'b1111, 4'd7, 4'd7, 8'b01001101, 6'sd6, 1'b0, DIV_LAT); wait_idle();

        // Backpressure: result held, op_valid ignored while pending.
        res_ready = 1'b0;
        issue(1'b0, 4'b1010, 4'b1110, 4'd8, 4'd7, 8'b10001100, 6'sd8, 1'b0, 3);
        n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_res_valid", {31'd0, res_valid}, 32'd1);
            check("bp_mant_stable", {24'd0, unnorm_mant}, 32'h8c);
            check("bp_op_ready", {31'd0, op_ready}, 32'd0);
            if (i == 1) begin
                op_valid = 1'b1; op_div = 1'b0; mant_a = 4'b1111; mant_b = 4'b1111;
            end
            if (i == 2) op_valid = 1'b0;
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_res_valid", {31'd0, res_valid}, 32'd0);
        check("bp_release_op_ready", {31'd0, op_ready}, 32'd1);
        wait_idle();

        // Reset during the third divide iteration.
        issue(1'b1, 4'b1000, 4'b1100, 4'd7, 4'd7, 8'b01010101, 6'sd6, 1'b0, DIV_LAT);
        repeat (3) @(negedge clk);
        check("mid_div_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_div_reset");
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1, 4'b1100, 4'b1000, 4'd7, 4'd7, 8'b01100000, 6'sd7, 1'b0, DIV_LAT); wait_idle();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
